// File: rtl/shape_sequencer.sv
// Splits one accepted draw command into primitive line/circle draws for the raster engine,
// stepping the opdata splitter select and registering each primitive's endpoints and colour.
module shape_sequencer #(
  parameter int POS_W = 19,
  parameter int COL_W = 16,
  parameter int SEL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_shape,
  output logic               cmd_ready,
  output logic [SEL_W-1:0]   output_sel,
  input  logic [2*POS_W-1:0] locations,
  input  logic [COL_W-1:0]   color,
  output logic               draw_start,
  output logic               draw_kind,
  output logic [POS_W-1:0]   draw_p0,
  output logic [POS_W-1:0]   draw_p1,
  output logic [COL_W-1:0]   draw_color,
  input  logic               draw_done,
  output logic               busy,
  output logic               shape_done,
  output logic               shape_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEL    = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [1:0] SHAPE_LINE   = 2'b00;
  localparam logic [1:0] SHAPE_TRI    = 2'b01;
  localparam logic [1:0] SHAPE_CIRCLE = 2'b10;

  localparam logic [SEL_W-1:0] SEL_LL1 = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_TL1 = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_CA1 = SEL_W'(4);

  logic [2:0] state;
  logic [1:0] seg_cnt;
  logic [1:0] seg_last;
  logic [1:0] kind_q;

  // Handshake and pulse outputs are pure state decodes, so they are clean during reset.
  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign draw_start = (state == S_LAUNCH);
  assign shape_done = (state == S_DONE);
  assign shape_err  = (state == S_ERR);

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      seg_cnt    <= 2'd0;
      seg_last   <= 2'd0;
      kind_q     <= 2'd0;
      output_sel <= SEL_LL1;
      draw_kind  <= 1'b0;
      draw_p0    <= '0;
      draw_p1    <= '0;
      draw_color <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            kind_q  <= cmd_shape;
            seg_cnt <= 2'd0;
            case (cmd_shape)
              SHAPE_LINE: begin
                output_sel <= SEL_LL1;
                seg_last   <= 2'd0;
                state      <= S_SEL;
              end
              SHAPE_TRI: begin
                output_sel <= SEL_TL1;
                seg_last   <= 2'd2;
                state      <= S_SEL;
              end
              SHAPE_CIRCLE: begin
                output_sel <= SEL_CA1;
                seg_last   <= 2'd0;
                state      <= S_SEL;
              end
              default: begin
                output_sel <= SEL_LL1;
                seg_last   <= 2'd0;
                state      <= S_ERR;
              end
            endcase
          end
        end
        // Splitter output has had a full cycle to settle on output_sel.
        S_SEL: begin
          draw_p0    <= locations[2*POS_W-1:POS_W];
          draw_p1    <= locations[POS_W-1:0];
          draw_color <= color;
          draw_kind  <= (kind_q == SHAPE_CIRCLE);
          state      <= S_LAUNCH;
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (draw_done) begin
            if (seg_cnt == seg_last) begin
              output_sel <= SEL_LL1;
              state      <= S_DONE;
            end else begin
              seg_cnt    <= seg_cnt + 2'd1;
              output_sel <= output_sel + SEL_W'(1);
              state      <= S_SEL;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_sequencer.sv
// Self-checking bench for shape_sequencer: directed table, random commands against a
// select-sequence model, spurious inputs and a mid-triangle reset abort.
module tb_shape_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_shape = 2'b00;
  logic        cmd_ready;
  logic [3:0]  output_sel;
  logic [37:0] locations;
  logic [15:0] color;
  logic        draw_start;
  logic        draw_kind;
  logic [18:0] draw_p0;
  logic [18:0] draw_p1;
  logic [15:0] draw_color;
  logic        draw_done = 1'b0;
  logic        busy;
  logic        shape_done;
  logic        shape_err;

  int tests = 0;
  int fails = 0;
  int n_starts = 0, n_dones = 0, n_errs = 0;
  int exp_starts = 0, exp_dones = 0, exp_errs = 0;

  always #5 clk = ~clk;

  shape_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_shape  (cmd_shape),
    .cmd_ready  (cmd_ready),
    .output_sel (output_sel),
    .locations  (locations),
    .color      (color),
    .draw_start (draw_start),
    .draw_kind  (draw_kind),
    .draw_p0    (draw_p0),
    .draw_p1    (draw_p1),
    .draw_color (draw_color),
    .draw_done  (draw_done),
    .busy       (busy),
    .shape_done (shape_done),
    .shape_err  (shape_err)
  );

  // Splitter model: one {p0, p1, colour} entry per select code.
  logic [18:0] sp_p0  [0:4];
  logic [18:0] sp_p1  [0:4];
  logic [15:0] sp_col [0:4];

  always_comb begin
    locations = '0;
    color     = '0;
    if (output_sel < 4'd5) begin
      locations = {sp_p0[output_sel[2:0]], sp_p1[output_sel[2:0]]};
      color     = sp_col[output_sel[2:0]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse counters are compared against the model's totals at the end.
  always @(negedge clk) begin
    if (draw_start) n_starts++;
    if (shape_done) n_dones++;
    if (shape_err)  n_errs++;
    tests++;
    if (output_sel > 4'd4) begin
      fails++;
      $display("FAIL sel_range: got %0h expected <=4 at %0t", output_sel, $time);
    end
  end

  function automatic int n_draws(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 3;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] sel_of(input logic [1:0] s, input int k);
    if (s == 2'b00) return 4'd0;
    if (s == 2'b01) return 4'(1 + k);
    return 4'd4;
  endfunction

  // Called at a negedge with cmd_ready expected high; returns at a negedge with cmd_ready high.
  task automatic run_cmd(input logic [1:0] shape, input int delay, input bit spurious,
                         input int abort_seg, output logic [3:0] f_sel, output logic f_kind,
                         output logic [18:0] f_p0, output logic [18:0] f_p1,
                         output logic [15:0] f_col);
    logic [3:0] s;
    f_sel = '0; f_kind = 1'b0; f_p0 = '0; f_p1 = '0; f_col = '0;
    check("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_shape = shape;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (shape == 2'b11) begin
      exp_errs++;
      check("err_pulse", shape_err, 1'b1);
      check("err_no_start", draw_start, 1'b0);
      check("err_ready_low", cmd_ready, 1'b0);
      @(negedge clk);
      check("err_pulse_end", shape_err, 1'b0);
      check("err_ready_back", cmd_ready, 1'b1);
      return;
    end
    for (int k = 0; k < n_draws(shape); k++) begin
      s = sel_of(shape, k);
      check("sel_step", output_sel, s);
      check("sel_no_start", draw_start, 1'b0);
      @(negedge clk);
      exp_starts++;
      check("start_pulse", draw_start, 1'b1);
      check("start_kind", draw_kind, shape == 2'b10);
      check("start_p0", draw_p0, sp_p0[s[2:0]]);
      check("start_p1", draw_p1, sp_p1[s[2:0]]);
      check("start_col", draw_color, sp_col[s[2:0]]);
      if (k == 0) begin
        f_sel = output_sel; f_kind = draw_kind; f_p0 = draw_p0; f_p1 = draw_p1; f_col = draw_color;
      end
      draw_done = spurious;
      if (k == abort_seg) begin
        @(negedge clk);
        draw_done = 1'b0;
        check("abort_in_wait", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("abort_ready", cmd_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_sel", output_sel, 4'd0);
        check("abort_p0", draw_p0, 19'd0);
        check("abort_kind", draw_kind, 1'b0);
        check("abort_col", draw_color, 16'd0);
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        check("abort_no_done", shape_done, 1'b0);
        check("abort_idle", cmd_ready, 1'b1);
        return;
      end
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        draw_done = 1'b0;
        check("wait_no_start", draw_start, 1'b0);
        check("wait_no_done", shape_done, 1'b0);
        check("wait_busy", busy, 1'b1);
        check("wait_sel_hold", output_sel, s);
        check("wait_p0_hold", draw_p0, sp_p0[s[2:0]]);
        check("wait_p1_hold", draw_p1, sp_p1[s[2:0]]);
        cmd_valid = 1'($urandom);
        cmd_shape = 2'($urandom);
      end
      cmd_valid = 1'b0;
      draw_done = 1'b1;
      @(negedge clk);
      draw_done = 1'b0;
    end
    exp_dones++;
    check("done_pulse", shape_done, 1'b1);
    check("done_sel_zero", output_sel, 4'd0);
    check("done_ready_low", cmd_ready, 1'b0);
    @(negedge clk);
    check("done_pulse_end", shape_done, 1'b0);
    check("done_ready_back", cmd_ready, 1'b1);
  endtask

  typedef struct {
    logic [1:0]  shape;
    int          delay;
    bit          spurious;
    logic [3:0]  exp_sel;
    logic        exp_kind;
    logic [18:0] exp_p0;
    logic [18:0] exp_p1;
    logic [15:0] exp_col;
  } vec_t;

  vec_t vecs [0:4];

  initial begin
    logic [3:0]  g_sel;
    logic        g_kind;
    logic [18:0] g_p0, g_p1;
    logic [15:0] g_col;

    sp_p0[0] = 19'h0A005; sp_p1[0] = 19'h1400A; sp_col[0] = 16'hF800;
    sp_p0[1] = 19'h01111; sp_p1[1] = 19'h02222; sp_col[1] = 16'h001F;
    sp_p0[2] = 19'h03333; sp_p1[2] = 19'h04444; sp_col[2] = 16'h07E0;
    sp_p0[3] = 19'h05555; sp_p1[3] = 19'h06666; sp_col[3] = 16'hFFE0;
    sp_p0[4] = 19'h28064; sp_p1[4] = 19'h00010; sp_col[4] = 16'h07FF;

    vecs[0] = '{2'b00, 5, 1'b0, 4'd0, 1'b0, 19'h0A005, 19'h1400A, 16'hF800};
    vecs[1] = '{2'b01, 2, 1'b1, 4'd1, 1'b0, 19'h01111, 19'h02222, 16'h001F};
    vecs[2] = '{2'b10, 3, 1'b0, 4'd4, 1'b1, 19'h28064, 19'h00010, 16'h07FF};
    vecs[3] = '{2'b11, 1, 1'b0, 4'd0, 1'b0, 19'h0,     19'h0,     16'h0};
    vecs[4] = '{2'b01, 1, 1'b0, 4'd1, 1'b0, 19'h01111, 19'h02222, 16'h001F};

    #12;
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_start", draw_start, 1'b0);
    check("rst_sel", output_sel, 4'd0);
    check("rst_p0", draw_p0, 19'd0);
    check("rst_p1", draw_p1, 19'd0);
    check("rst_done_err", {shape_done, shape_err, draw_kind}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    check("idle_spurious_busy", busy, 1'b0);
    check("idle_spurious_start", draw_start, 1'b0);
    check("idle_spurious_ready", cmd_ready, 1'b1);

    for (int v = 0; v < 5; v++) begin
      run_cmd(vecs[v].shape, vecs[v].delay, vecs[v].spurious, -1, g_sel, g_kind, g_p0, g_p1, g_col);
      if (vecs[v].shape != 2'b11) begin
        check("vec_sel", g_sel, vecs[v].exp_sel);
        check("vec_kind", g_kind, vecs[v].exp_kind);
        check("vec_p0", g_p0, vecs[v].exp_p0);
        check("vec_p1", g_p1, vecs[v].exp_p1);
        check("vec_col", g_col, vecs[v].exp_col);
      end
    end

    exp_starts++;
    run_cmd(2'b01, 3, 1'b0, 1, g_sel, g_kind, g_p0, g_p1, g_col);
    run_cmd(2'b00, 2, 1'b0, -1, g_sel, g_kind, g_p0, g_p1, g_col);
    check("post_abort_line_p0", g_p0, 19'h0A005);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 5; i++) begin
        sp_p0[i]  = 19'($urandom);
        sp_p1[i]  = 19'($urandom);
        sp_col[i] = 16'($urandom);
      end
      run_cmd(2'($urandom), int'($urandom_range(1, 4)), 1'($urandom), -1,
              g_sel, g_kind, g_p0, g_p1, g_col);
    end

    @(negedge clk);
    #1;
    // The aborted triangle's first edge was counted before the abort; its second is
    // counted by run_cmd itself, so remove the pre-bump added above.
    exp_starts--;
    check("total_starts", n_starts, exp_starts);
    check("total_dones", n_dones, exp_dones);
    check("total_errs", n_errs, exp_errs);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shape_sequencer.md
Name: shape_sequencer

Overview:
- Drives the segment-select input of the opdata splitter and consumes its `locations`/`color` outputs.
- Decomposes one accepted draw command into a sequence of primitive draws, issued one at a time to the line/circle raster engine:
  - line: 1 segment
  - triangle: 3 edges
  - circle: 1 centre/radius draw
- Sits between the command FIFO/decoder (which holds opdata stable) and the raster engine.

Parameters:
- POS_W, 19, width of one packed position (10-bit x, 9-bit y)
- COL_W, 16, colour width (5r/6g/5b)
- SEL_W, 4, width of the splitter select code

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present; upstream holds opdata stable until shape_done/shape_err
- cmd_shape  in  2  00 line, 01 triangle, 10 circle, 11 reserved
- cmd_ready  out  1  high while in IDLE
- output_sel  out  SEL_W  to splitter: 0000 LL1, 0001 TL1, 0010 TL2, 0011 TL3, 0100 CA1
- locations  in  2*POS_W  from splitter: {first position, second position}
- color  in  COL_W  from splitter
- draw_start  out  1  one-cycle pulse to raster engine
- draw_kind  out  1  0 line, 1 circle; valid with draw_start
- draw_p0  out  POS_W  start point or circle centre (registered)
- draw_p1  out  POS_W  end point or radius (registered)
- draw_color  out  COL_W  registered colour
- draw_done  in  1  one-cycle pulse from raster engine: primitive finished
- busy  out  1  high in every state except IDLE
- shape_done  out  1  one-cycle pulse: all segments drawn
- shape_err  out  1  one-cycle pulse: reserved shape code rejected

Behaviour:
- Reset (asynchronous, active-high):
  - State → IDLE, seg_cnt = 0, seg_last = 0, kind register = 0.
  - output_sel = 0000; draw_start, draw_kind, draw_p0, draw_p1, draw_color, busy, shape_done, shape_err all 0.
  - cmd_ready = 1 (decoded from IDLE, so also high while rst is asserted).
- States: IDLE, SEL, LAUNCH, WAIT, DONE, ERR.
- IDLE:
  - cmd_ready = 1.
  - A handshake (cmd_valid & cmd_ready) latches the shape.
  - Next state is ERR for code 11; otherwise SEL.
  - Initial output_sel: 0000 for line, 0001 for triangle, 0100 for circle.
  - seg_last is set to 2 for triangle and 0 otherwise; seg_cnt = 0.
- SEL:
  - Lasts one cycle; output_sel is stable and the combinational splitter output settles.
  - On the exiting edge, locations[37:19] is captured into draw_p0, locations[18:0] into draw_p1, and color into draw_color.
  - draw_kind is set to 1 only for circle. → LAUNCH.
- LAUNCH:
  - draw_start = 1 for exactly one cycle; draw_p0/p1/color/kind are held. → WAIT.
- WAIT:
  - Held until draw_done = 1.
  - If seg_cnt == seg_last → DONE.
  - Otherwise seg_cnt += 1, output_sel += 1 (TL1→TL2→TL3), → SEL.
  - draw_done in any state other than WAIT is ignored.
- DONE: shape_done = 1 for one cycle; output_sel returns to 0000. → IDLE.
- ERR: shape_err = 1 for one cycle; no draw_start is issued. → IDLE.
- Output stability: draw_p0/p1/color/kind change only on the SEL exit edge and hold through LAUNCH and WAIT.
- Latency:
  - From the accept edge (T0), draw_start is high in cycle T0+2.
  - After draw_done is sampled in WAIT, the next draw_start for a triangle follows 2 cycles later.
  - shape_done occurs in the cycle after the final draw_done; cmd_ready returns the cycle after that.
- Back-to-back commands: cmd_valid is not accepted during DONE/ERR. The earliest next accept is the cycle after the shape_done/shape_err pulse.
- Counter limits: seg_cnt is 2 bits and never exceeds seg_last. output_sel never leaves the set {0000, 0001, 0010, 0011, 0100}.
- Reset mid-operation:
  - The state machine aborts immediately.
  - No shape_done is issued, and any in-flight draw_done is discarded.
  - The raster engine shares rst.
- Simultaneous events: cmd_valid asserted during busy has no effect (not latched, not queued).

Test Plan:
- Reset: assert rst mid-cycle with no clock edge → outputs are zero, output_sel = 0000, cmd_ready = 1 asynchronously.
- Line:
  - Stimulus: cmd_shape = 00, splitter model returns p0 = 0x0A005, p1 = 0x1400A, color = 0xF800.
  - Response: draw_start in cycle T0+2 with draw_kind = 0 and those exact values; draw_done after 5 cycles → shape_done one cycle later, then cmd_ready = 1.
- Triangle:
  - Stimulus: cmd_shape = 01, distinct pairs per select.
  - Response: output_sel steps 0001, 0010, 0011; three draw_start pulses, each with the matching pair; exactly one shape_done after the third draw_done.
- Circle:
  - Stimulus: cmd_shape = 10, centre 0x28064, radius 0x00010.
  - Response: output_sel = 0100, draw_kind = 1, draw_p1 = 0x00010; single draw.
- Error and spurious inputs:
  - cmd_shape = 11 → shape_err pulse at T0+1, no draw_start, cmd_ready high at T0+2.
  - draw_done pulsed in IDLE/LAUNCH → ignored.
- Abort: assert rst while in WAIT of the second triangle edge → IDLE immediately, no shape_done; a new line command then completes normally.
